// File: rtl/stopwatch_sequencer.sv
// Purpose : front-panel sequencer turning debounced button pulses into run/direction/clear/load
//           strobes for the BCD stopwatch chain, with countdown preset editing and expiry alarm.
// Latency : one cycle from button pulse (or at_zero) to registered state/output change.
// Backpr. : none; pulses are consumed in the cycle they arrive, lower-priority coincident pulses are dropped.
//
// Ports:
//   clock, reset_n            - 100 MHz clock, async active-low reset
//   tick_100ms                - 100 ms enable (counts alarm duration)
//   start_stop_btn, clear_btn, mode_btn, inc_btn - one-cycle button pulses
//   count_down, at_zero       - mode switch and datapath all-zero flag
//   run_en, direction, clear_pulse, load_pulse   - datapath controls
//   preset_minute/sec_tens/sec_units, edit_sel, edit_active - countdown preset and editing view
//   alarm, state              - expiry indicator and FSM debug view
//
// Build option: define STOPWATCH_SEQ_ALARM_EN to include the EXPIRED state, alarm counter
// and ALARM_TICKS parameter. Without it, a countdown reaching zero returns straight to IDLE.
module stopwatch_sequencer
`ifdef STOPWATCH_SEQ_ALARM_EN
  #(parameter int ALARM_TICKS = 30)
`endif
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tick_100ms,
  input  logic       start_stop_btn,
  input  logic       clear_btn,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       count_down,
  input  logic       at_zero,
  output logic       run_en,
  output logic       direction,
  output logic       clear_pulse,
  output logic       load_pulse,
  output logic [3:0] preset_minute,
  output logic [3:0] preset_sec_tens,
  output logic [3:0] preset_sec_units,
  output logic [1:0] edit_sel,
  output logic       edit_active,
  output logic       alarm,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EDIT    = 3'd1,
    ST_LOAD    = 3'd2,
    ST_RUN     = 3'd3,
    ST_PAUSE   = 3'd4,
    ST_EXPIRED = 3'd5
  } state_t;

  state_t state_q;
  state_t state_nxt;

  // Only the highest-priority pulse in a cycle is acted on.
  logic clr_act, ss_act, mode_act, inc_act;
  assign clr_act  = clear_btn;
  assign ss_act   = start_stop_btn & ~clear_btn;
  assign mode_act = mode_btn & ~start_stop_btn & ~clear_btn;
  assign inc_act  = inc_btn & ~mode_btn & ~start_stop_btn & ~clear_btn;

  logic preset_nz;
  assign preset_nz = |{preset_minute, preset_sec_tens, preset_sec_units};

  logic clr_set;       // raise clear_pulse next cycle
  logic preset_zero;   // EDIT-mode clear of the preset
  logic digit_inc;     // increment selected preset digit
  logic sel_adv;       // advance edit_sel

`ifdef STOPWATCH_SEQ_ALARM_EN
  localparam int CW = $clog2(ALARM_TICKS + 1);
  logic [CW-1:0] alarm_cnt;
  logic          alarm_done;
  assign alarm_done = tick_100ms && (alarm_cnt == CW'(ALARM_TICKS - 1));
`else
  logic unused_tick;
  assign unused_tick = tick_100ms;
`endif

  always_comb begin
    state_nxt   = state_q;
    clr_set     = 1'b0;
    preset_zero = 1'b0;
    digit_inc   = 1'b0;
    sel_adv     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_act) begin
          clr_set = 1'b1;
        end else if (ss_act) begin
          if (!count_down)    state_nxt = ST_RUN;
          else if (preset_nz) state_nxt = ST_LOAD;
        end else if (mode_act && count_down) begin
          state_nxt = ST_EDIT;
        end
      end
      ST_EDIT: begin
        if (clr_act) begin
          preset_zero = 1'b1;
        end else if (ss_act) begin
          // start/stop has no meaning while editing
        end else if (mode_act) begin
          sel_adv = 1'b1;
          if (edit_sel == 2'd2) state_nxt = ST_IDLE;
        end else if (inc_act) begin
          digit_inc = 1'b1;
        end
      end
      ST_LOAD: state_nxt = ST_RUN;
      ST_RUN: begin
        if (clr_act) begin
          clr_set   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (ss_act) begin
          state_nxt = ST_PAUSE;
        end else if (!direction && at_zero) begin
`ifdef STOPWATCH_SEQ_ALARM_EN
          state_nxt = ST_EXPIRED;
`else
          // display holds 0:00.0, so no clear here
          state_nxt = ST_IDLE;
`endif
        end
      end
      ST_PAUSE: begin
        if (clr_act) begin
          clr_set   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (ss_act) begin
          state_nxt = ST_RUN;
        end
      end
`ifdef STOPWATCH_SEQ_ALARM_EN
      ST_EXPIRED: begin
        if (clr_act) begin
          clr_set   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (ss_act || alarm_done) begin
          state_nxt = ST_IDLE;
        end
      end
`endif
      default: state_nxt = ST_IDLE;  // illegal codes recover
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ST_IDLE;
      run_en           <= 1'b0;
      direction        <= 1'b1;
      clear_pulse      <= 1'b0;
      load_pulse       <= 1'b0;
      edit_active      <= 1'b0;
      edit_sel         <= 2'd0;
      preset_minute    <= 4'd0;
      preset_sec_tens  <= 4'd0;
      preset_sec_units <= 4'd0;
    end else begin
      state_q     <= state_nxt;
      // outputs are registered copies of the next state so they line up with it
      run_en      <= (state_nxt == ST_RUN);
      load_pulse  <= (state_nxt == ST_LOAD);
      edit_active <= (state_nxt == ST_EDIT);
      clear_pulse <= clr_set;

      if (state_q == ST_IDLE && state_nxt != ST_IDLE)
        direction <= ~count_down;

      if (sel_adv)
        edit_sel <= (edit_sel == 2'd2) ? 2'd0 : edit_sel + 2'd1;

      if (preset_zero) begin
        preset_minute    <= 4'd0;
        preset_sec_tens  <= 4'd0;
        preset_sec_units <= 4'd0;
      end else if (digit_inc) begin
        case (edit_sel)
          2'd0:    preset_minute    <= (preset_minute    == 4'd9) ? 4'd0 : preset_minute    + 4'd1;
          2'd1:    preset_sec_tens  <= (preset_sec_tens  == 4'd5) ? 4'd0 : preset_sec_tens  + 4'd1;
          2'd2:    preset_sec_units <= (preset_sec_units == 4'd9) ? 4'd0 : preset_sec_units + 4'd1;
          default: ;
        endcase
      end
    end
  end

`ifdef STOPWATCH_SEQ_ALARM_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      alarm     <= 1'b0;
      alarm_cnt <= '0;
    end else begin
      alarm <= (state_nxt == ST_EXPIRED);
      // counter only advances while staying expired; any exit rearms it
      if (state_nxt != ST_EXPIRED)
        alarm_cnt <= '0;
      else if (state_q == ST_EXPIRED && tick_100ms)
        alarm_cnt <= alarm_cnt + CW'(1);
    end
  end
`else
  assign alarm = 1'b0;
`endif

  assign state = state_q;

endmodule

// File: tb/tb_stopwatch_sequencer.sv
module tb_stopwatch_sequencer;

  logic       clock = 1'b0;
  logic       reset_n, tick_100ms, start_stop_btn, clear_btn, mode_btn, inc_btn;
  logic       count_down, at_zero;
  logic       run_en, direction, clear_pulse, load_pulse, edit_active, alarm;
  logic [3:0] preset_minute, preset_sec_tens, preset_sec_units;
  logic [1:0] edit_sel;
  logic [2:0] state;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  stopwatch_sequencer dut (
    .clock(clock), .reset_n(reset_n), .tick_100ms(tick_100ms),
    .start_stop_btn(start_stop_btn), .clear_btn(clear_btn), .mode_btn(mode_btn),
    .inc_btn(inc_btn), .count_down(count_down), .at_zero(at_zero),
    .run_en(run_en), .direction(direction), .clear_pulse(clear_pulse),
    .load_pulse(load_pulse), .preset_minute(preset_minute),
    .preset_sec_tens(preset_sec_tens), .preset_sec_units(preset_sec_units),
    .edit_sel(edit_sel), .edit_active(edit_active), .alarm(alarm), .state(state)
  );

  // advance n clocks, then settle 1 time unit past the edge
  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // 0=start 1=clear 2=mode 3=inc 4=tick 5=at_zero ; one-cycle pulse
  task automatic press(input int which);
    case (which)
      0: start_stop_btn = 1'b1;
      1: clear_btn      = 1'b1;
      2: mode_btn       = 1'b1;
      3: inc_btn        = 1'b1;
      4: tick_100ms     = 1'b1;
      default: at_zero  = 1'b1;
    endcase
    cyc(1);
    start_stop_btn = 1'b0; clear_btn = 1'b0; mode_btn = 1'b0;
    inc_btn = 1'b0; tick_100ms = 1'b0; at_zero = 1'b0;
  endtask

  task automatic press_n(input int which, input int n);
    for (int i = 0; i < n; i++) press(which);
  endtask

  task automatic test_reset;
    reset_n = 1'b0; tick_100ms = 1'b0; start_stop_btn = 1'b0; clear_btn = 1'b0;
    mode_btn = 1'b0; inc_btn = 1'b0; count_down = 1'b0; at_zero = 1'b0;
    cyc(3);
    reset_n = 1'b1;
    cyc(1);
    tests++; if (state !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", state); end
    tests++; if (direction !== 1'b1) begin fails++; $display("FAIL reset_direction: got %b want 1", direction); end
    tests++; if ({run_en, clear_pulse, load_pulse, edit_active, alarm} !== 5'b0) begin
      fails++; $display("FAIL reset_strobes: got %b want 00000", {run_en, clear_pulse, load_pulse, edit_active, alarm}); end
    tests++; if ({edit_sel, preset_minute, preset_sec_tens, preset_sec_units} !== 14'd0) begin
      fails++; $display("FAIL reset_preset: got %h want 0", {edit_sel, preset_minute, preset_sec_tens, preset_sec_units}); end
  endtask

  task automatic test_count_up;
    logic seen_load;
    count_down = 1'b0;
    cyc(9);
    press(0);
    tests++; if (run_en !== 1'b1) begin fails++; $display("FAIL up_run_en: got %b want 1", run_en); end
    tests++; if (state !== 3'd3) begin fails++; $display("FAIL up_state: got %0d want 3", state); end
    tests++; if (direction !== 1'b1) begin fails++; $display("FAIL up_direction: got %b want 1", direction); end
    seen_load = load_pulse;
    for (int i = 0; i < 6; i++) begin cyc(1); seen_load |= load_pulse; end
    press(5);  // at_zero is ignored while counting up
    seen_load |= load_pulse;
    tests++; if (seen_load !== 1'b0) begin fails++; $display("FAIL up_no_load: got %b want 0", seen_load); end
    tests++; if (state !== 3'd3) begin fails++; $display("FAIL up_at_zero_ignored: got %0d want 3", state); end
    press(1);
    tests++; if ({state, clear_pulse, run_en} !== 5'b000_1_0) begin
      fails++; $display("FAIL up_clear: got state=%0d clr=%b run=%b want 0 1 0", state, clear_pulse, run_en); end
    cyc(1);
    tests++; if (clear_pulse !== 1'b0) begin fails++; $display("FAIL up_clear_one_cycle: got %b want 0", clear_pulse); end
  endtask

  task automatic test_zero_preset;
    count_down = 1'b1;
    press(0);
    tests++; if (state !== 3'd0) begin fails++; $display("FAIL zero_preset_state: got %0d want 0", state); end
    cyc(1);
    tests++; if ({run_en, load_pulse} !== 2'b00) begin fails++; $display("FAIL zero_preset_run: got %b want 00", {run_en, load_pulse}); end
  endtask

  task automatic test_edit;
    count_down = 1'b1;
    press(2);
    tests++; if ({state, edit_active, edit_sel} !== 6'b001_1_00) begin
      fails++; $display("FAIL edit_enter: got state=%0d act=%b sel=%0d want 1 1 0", state, edit_active, edit_sel); end
    tests++; if (direction !== 1'b0) begin fails++; $display("FAIL edit_direction: got %b want 0", direction); end
    press_n(3, 3);
    press(2);
    press_n(3, 7);
    tests++; if ({preset_minute, preset_sec_tens, edit_sel} !== {4'd3, 4'd1, 2'd1}) begin
      fails++; $display("FAIL edit_digits: got %0d %0d sel %0d want 3 1 1", preset_minute, preset_sec_tens, edit_sel); end
    press(0);  // ignored in EDIT
    tests++; if (state !== 3'd1) begin fails++; $display("FAIL edit_start_ignored: got %0d want 1", state); end
    press(2);
    press(2);
    tests++; if ({state, edit_active, edit_sel} !== 6'b000_0_00) begin
      fails++; $display("FAIL edit_exit: got state=%0d act=%b sel=%0d want 0 0 0", state, edit_active, edit_sel); end
    tests++; if ({preset_minute, preset_sec_tens, preset_sec_units} !== 12'h310) begin
      fails++; $display("FAIL edit_retained: got %h want 310", {preset_minute, preset_sec_tens, preset_sec_units}); end
    // re-enter, clear preset, mode+inc together (mode wins), set units to 1
    press(2);
    press(1);
    tests++; if ({state, preset_minute, preset_sec_tens, preset_sec_units} !== {3'd1, 12'h000}) begin
      fails++; $display("FAIL edit_clear: got state=%0d preset=%h want 1 000", state, {preset_minute, preset_sec_tens, preset_sec_units}); end
    mode_btn = 1'b1; inc_btn = 1'b1;
    cyc(1);
    mode_btn = 1'b0; inc_btn = 1'b0;
    tests++; if ({edit_sel, preset_minute} !== {2'd1, 4'd0}) begin
      fails++; $display("FAIL edit_mode_over_inc: got sel=%0d min=%0d want 1 0", edit_sel, preset_minute); end
    press(2);
    press(3);
    press(2);
    tests++; if ({state, preset_minute, preset_sec_tens, preset_sec_units} !== {3'd0, 12'h001}) begin
      fails++; $display("FAIL edit_preset_001: got state=%0d preset=%h want 0 001", state, {preset_minute, preset_sec_tens, preset_sec_units}); end
  endtask

  // starts a countdown from IDLE and checks the load/run handoff
  task automatic start_countdown(input string tag);
    count_down = 1'b1;
    press(0);
    tests++; if ({state, load_pulse, run_en, clear_pulse} !== 6'b010_1_0_0) begin
      fails++; $display("FAIL %s_load: got state=%0d ld=%b run=%b clr=%b want 2 1 0 0", tag, state, load_pulse, run_en, clear_pulse); end
    cyc(1);
    tests++; if ({state, load_pulse, run_en, direction} !== 6'b011_0_1_0) begin
      fails++; $display("FAIL %s_run: got state=%0d ld=%b run=%b dir=%b want 3 0 1 0", tag, state, load_pulse, run_en, direction); end
  endtask

  task automatic test_countdown_alarm;
    start_countdown("cd");
    for (int i = 0; i < 10; i++) begin press(4); cyc(2); end
    press(5);
`ifdef STOPWATCH_SEQ_ALARM_EN
    tests++; if ({state, run_en, alarm} !== 5'b101_0_1) begin
      fails++; $display("FAIL cd_expire: got state=%0d run=%b alarm=%b want 5 0 1", state, run_en, alarm); end
    for (int i = 0; i < 29; i++) begin press(4); cyc(3); end
    tests++; if ({state, alarm} !== 4'b101_1) begin
      fails++; $display("FAIL cd_alarm_29: got state=%0d alarm=%b want 5 1", state, alarm); end
    press(4);
    tests++; if ({state, alarm, clear_pulse} !== 5'b000_0_0) begin
      fails++; $display("FAIL cd_alarm_30: got state=%0d alarm=%b clr=%b want 0 0 0", state, alarm, clear_pulse); end
`else
    tests++; if ({state, run_en, alarm, clear_pulse} !== 6'b000_0_0_0) begin
      fails++; $display("FAIL cd_zero_idle: got state=%0d run=%b alarm=%b clr=%b want 0 0 0 0", state, run_en, alarm, clear_pulse); end
`endif
    tests++; if (preset_sec_units !== 4'd1) begin fails++; $display("FAIL cd_preset_kept: got %0d want 1", preset_sec_units); end
  endtask

`ifdef STOPWATCH_SEQ_ALARM_EN
  task automatic test_expired_early;
    start_countdown("ex1");
    press(5);
    for (int i = 0; i < 5; i++) begin press(4); cyc(1); end
    press(0);
    tests++; if ({state, alarm, clear_pulse} !== 5'b000_0_0) begin
      fails++; $display("FAIL ex_start_exit: got state=%0d alarm=%b clr=%b want 0 0 0", state, alarm, clear_pulse); end
    start_countdown("ex2");
    press(5);
    for (int i = 0; i < 29; i++) press(4);
    tests++; if ({state, alarm} !== 4'b101_1) begin
      fails++; $display("FAIL ex_counter_rearmed: got state=%0d alarm=%b want 5 1", state, alarm); end
    press(1);
    tests++; if ({state, alarm, clear_pulse} !== 5'b000_0_1) begin
      fails++; $display("FAIL ex_clear_exit: got state=%0d alarm=%b clr=%b want 0 0 1", state, alarm, clear_pulse); end
  endtask
`endif

  task automatic test_clear_priority;
    count_down = 1'b0;
    press(0);
    clear_btn = 1'b1; start_stop_btn = 1'b1;
    cyc(1);
    clear_btn = 1'b0; start_stop_btn = 1'b0;
    tests++; if ({state, clear_pulse, run_en} !== 5'b000_1_0) begin
      fails++; $display("FAIL prio_clear: got state=%0d clr=%b run=%b want 0 1 0", state, clear_pulse, run_en); end
    cyc(1);
    tests++; if (clear_pulse !== 1'b0) begin fails++; $display("FAIL prio_clear_one_cycle: got %b want 0", clear_pulse); end
    press(0);
    press(0);
    tests++; if ({state, run_en} !== 4'b100_0) begin
      fails++; $display("FAIL pause: got state=%0d run=%b want 4 0", state, run_en); end
    press(0);
    tests++; if ({state, run_en} !== 4'b011_1) begin
      fails++; $display("FAIL resume: got state=%0d run=%b want 3 1", state, run_en); end
    press(0);
    press(1);
    tests++; if ({state, clear_pulse} !== 4'b000_1) begin
      fails++; $display("FAIL pause_clear: got state=%0d clr=%b want 0 1", state, clear_pulse); end
  endtask

  task automatic test_reset_midrun;
    count_down = 1'b1;
    press(2); press(1);
    press_n(3, 5); press(2);
    press_n(3, 3); press(2); press(2);
    tests++; if ({state, preset_minute, preset_sec_tens, preset_sec_units} !== {3'd0, 12'h530}) begin
      fails++; $display("FAIL rst_preset_530: got state=%0d preset=%h want 0 530", state, {preset_minute, preset_sec_tens, preset_sec_units}); end
    start_countdown("rst");
    press(0);
    tests++; if (state !== 3'd4) begin fails++; $display("FAIL rst_in_pause: got %0d want 4", state); end
    reset_n = 1'b0;
    cyc(3);
    reset_n = 1'b1;
    cyc(1);
    tests++; if ({state, direction, run_en, clear_pulse, load_pulse, alarm} !== 8'b000_1_0_0_0_0) begin
      fails++; $display("FAIL rst_outputs: got state=%0d dir=%b run=%b clr=%b ld=%b alarm=%b want 0 1 0 0 0 0",
                        state, direction, run_en, clear_pulse, load_pulse, alarm); end
    tests++; if ({preset_minute, preset_sec_tens, preset_sec_units} !== 12'h000) begin
      fails++; $display("FAIL rst_preset_cleared: got %h want 000", {preset_minute, preset_sec_tens, preset_sec_units}); end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_zero_preset();
    test_edit();
    test_countdown_alarm();
`ifdef STOPWATCH_SEQ_ALARM_EN
    test_expired_early();
`endif
    test_clear_priority();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
